cdc_hs_src: RTL and testbench

Source-side controller for a 4-phase req/ack bus-synchronizer transfer. It accepts one word on a valid/ready interface, holds it stable on xfer_data, and sequences xfer_req against the far-domain acknowledge. The acknowledge is resynchronised through an internal multi-stage flop chain. The block sits in the sending clock domain; the paired receiver samples xfer_data only while its synchronised xfer_req is high.

---
 rtl/cdc_hs_pkg.sv | 16 +
 rtl/sync_ff_srst.sv | 26 ++
 rtl/cdc_hs_src.sv | 118 +++++++++++
 tb/tb_cdc_hs_src.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_hs_pkg.sv
// Shared types and constants for the req/ack source-side transfer controller.
package cdc_hs_pkg;

  // Transfer controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } hs_state_e;

  // Acknowledge resynchroniser depth: default and legal bounds.
  localparam int ACK_SYNC_STAGES_DEF = 2;
  localparam int ACK_SYNC_STAGES_MIN = 2;
  localparam int ACK_SYNC_STAGES_MAX = 4;

endpackage : cdc_hs_pkg

// File: rtl/sync_ff_srst.sv
// N-stage single-bit synchronizer with synchronous active-high reset.
// The input may be fully asynchronous to aclk; the output is the last stage.
// STAGES is expected to be at least 2.
module sync_ff_srst #(
  parameter int STAGES = 2
) (
  input  logic aclk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the flop chain, clearing on reset.
  always_ff @(posedge aclk) begin
    if (srst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule : sync_ff_srst

// File: rtl/cdc_hs_src.sv
// Source-side controller for a 4-phase req/ack bus-synchronizer transfer.
// Handshakes:
//   s_valid/s_ready : a word moves when both are high at a rising edge of aclk;
//                     the source holds s_valid and s_data until that edge.
//   xfer_req/ack    : 4-phase. xfer_req rises with a new word on xfer_data,
//                     falls once the synchronised ack is seen high, and the
//                     next word is only accepted after ack has returned low.
//                     xfer_data is stable from accept until the next accept.
module cdc_hs_src
  import cdc_hs_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int ACK_SYNC_STAGES = ACK_SYNC_STAGES_DEF,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                  aclk,
  input  logic                  srst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  xfer_req,
  output logic [DATA_WIDTH-1:0] xfer_data,
  input  logic                  xfer_ack_async,
  output logic                  busy,
  output logic                  timeout_err,
  input  logic                  err_clr
);

  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  hs_state_e             state;
  hs_state_e             state_d;
  logic                  req_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  err_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic                  ack_s;

  sync_ff_srst #(
    .STAGES (ACK_SYNC_STAGES)
  ) u_ack_sync (
    .aclk (aclk),
    .srst (srst),
    .d    (xfer_ack_async),
    .q    (ack_s)
  );

  // Accept only from IDLE and only once the far side has released ack.
  assign s_ready = (state == IDLE) && !ack_s && !srst;
  assign busy    = (state != IDLE);

  // Next-state, request, held word, sticky error and REQ-cycle counter.
  always_comb begin
    state_d = state;
    req_d   = xfer_req;
    data_d  = xfer_data;
    err_d   = timeout_err;
    cnt_d   = '0;
    if (err_clr) begin
      err_d = 1'b0;
    end
    case (state)
      IDLE: begin
        if (s_valid && s_ready) begin
          data_d  = s_data;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          // An ack landing on the last timeout cycle still wins.
          req_d   = 1'b0;
          state_d = REL;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          // Setting the error overrides a simultaneous err_clr.
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = REL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REL: begin
        if (!ack_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Register state, outputs and counter; reset drops the request immediately.
  always_ff @(posedge aclk) begin
    if (srst) begin
      state       <= IDLE;
      xfer_req    <= 1'b0;
      xfer_data   <= '0;
      timeout_err <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state       <= state_d;
      xfer_req    <= req_d;
      xfer_data   <= data_d;
      timeout_err <= err_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule : cdc_hs_src

// File: tb/tb_cdc_hs_src.sv
// Bench for cdc_hs_src: directed steps plus randomized words and ack latencies,
// checked against arithmetic timing rules and a word-order scoreboard.
module tb_cdc_hs_src;

  localparam int DW         = 8;
  localparam int S          = 2;
  localparam int T          = 16;
  localparam int MIN_PERIOD = 2 + 2 * S;
  localparam int N_STREAM   = 15;

  logic          aclk      = 1'b0;
  logic          srst      = 1'b1;
  logic          s_valid   = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data    = '0;
  logic          xfer_req;
  logic [DW-1:0] xfer_data;
  logic          xfer_ack_async;
  logic          busy;
  logic          timeout_err;
  logic          err_clr   = 1'b0;

  logic ack_dir  = 1'b0;
  logic ack_auto = 1'b0;
  logic auto_ack = 1'b0;
  assign xfer_ack_async = auto_ack ? ack_auto : ack_dir;

  int n_checks   = 0;
  int n_fail     = 0;
  int rx_count   = 0;
  int req_pulses = 0;
  logic [DW-1:0] exp_q[$];

  cdc_hs_src #(
    .DATA_WIDTH      (DW),
    .ACK_SYNC_STAGES (S),
    .TIMEOUT_CYCLES  (T)
  ) dut (
    .aclk           (aclk),
    .srst           (srst),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .xfer_req       (xfer_req),
    .xfer_data      (xfer_data),
    .xfer_ack_async (xfer_ack_async),
    .busy           (busy),
    .timeout_err    (timeout_err),
    .err_clr        (err_clr)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, expected end within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Directed accept from IDLE: word moves at the next edge.
  task automatic accept_word(input logic [DW-1:0] w);
    check("ready_before_accept", s_ready, 1'b1);
    s_valid = 1'b1;
    s_data  = w;
    tick();
    s_valid = 1'b0;
    check("accept_req", xfer_req, 1'b1);
    check("accept_data", xfer_data, w);
    check("accept_busy", busy, 1'b1);
    check("accept_ready_low", s_ready, 1'b0);
  endtask

  // Present a word and hold it until accepted; scoreboard it on accept.
  task automatic send_word_auto(input logic [DW-1:0] w);
    int   waited;
    logic acc;
    waited  = 0;
    acc     = 1'b0;
    s_valid = 1'b1;
    s_data  = w;
    while (!acc && waited < 200) begin
      acc = s_ready;
      tick();
      waited++;
    end
    check("stream_accept_wait", acc, 1'b1);
    if (acc) exp_q.push_back(w);
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while ((busy || exp_q.size() != 0 || ack_auto) && waited < 400) begin
      tick();
      waited++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_idle", busy, 1'b0);
  endtask

  // ---------------- far-side model ----------------
  // Raises ack some cycles after seeing req high (capturing the word), and
  // drops it some cycles after seeing req low.
  int far_wait = 0;
  always @(negedge aclk) begin
    if (!auto_ack) begin
      ack_auto = 1'b0;
      far_wait = $urandom_range(0, 3);
    end else if (xfer_req != ack_auto) begin
      if (far_wait > 0) begin
        far_wait--;
      end else begin
        if (xfer_req) begin
          rx_count++;
          check("rx_word_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) check("rx_word", xfer_data, exp_q.pop_front());
        end
        ack_auto = xfer_req;
        far_wait = $urandom_range(0, 3);
      end
    end
  end

  // ---------------- interface rule monitor ----------------
  // Values seen at a falling edge are what the next rising edge samples.
  logic          p_srst    = 1'b1;
  logic          p_acc     = 1'b0;
  logic [DW-1:0] p_data    = '0;
  logic [DW-1:0] last_data = '0;
  logic          prev_req  = 1'b0;
  int            since_acc = 1000;
  always @(negedge aclk) begin
    since_acc++;
    if (p_srst) begin
      check("mon_rst_data", xfer_data, '0);
      check("mon_rst_req", xfer_req, 1'b0);
      check("mon_rst_busy", busy, 1'b0);
      since_acc = 1000;
    end else if (p_acc) begin
      check("mon_acc_data", xfer_data, p_data);
      check("mon_acc_req", xfer_req, 1'b1);
      check("mon_acc_period", since_acc >= MIN_PERIOD, 1'b1);
      since_acc = 0;
    end else begin
      check("mon_data_held", xfer_data, last_data);
    end
    check("mon_ready_not_busy", s_ready && busy, 1'b0);
    if (auto_ack && xfer_req && !prev_req) req_pulses++;
    prev_req  = xfer_req;
    last_data = xfer_data;
    p_acc     = s_valid && s_ready;
    p_srst    = srst;
    p_data    = s_data;
  end

  // ---------------- directed sequence ----------------
  initial begin
    // Reset
    srst = 1'b1;
    repeat (3) tick();
    check("rst_req", xfer_req, 1'b0);
    check("rst_data", xfer_data, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", timeout_err, 1'b0);
    check("rst_ready", s_ready, 1'b0);
    srst = 1'b0;
    #1;
    check("post_rst_ready", s_ready, 1'b1);

    // Basic transfer of A5 with a manual ack
    accept_word(8'hA5);
    repeat (3) begin
      tick();
      check("basic_req_wait", xfer_req, 1'b1);
    end
    ack_dir = 1'b1;
    for (int k = 1; k <= S + 1; k++) begin
      tick();
      check("basic_req_fall", xfer_req, k < S + 1);
    end
    check("basic_rel_busy", busy, 1'b1);
    repeat (2) begin
      tick();
      check("basic_rel_ready", s_ready, 1'b0);
    end
    ack_dir = 1'b0;
    for (int k = 1; k <= S + 1; k++) begin
      tick();
      check("basic_busy_release", busy, k < S + 1);
      check("basic_ready_return", s_ready, k == S + 1);
    end
    check("basic_data_held", xfer_data, 8'hA5);

    // Ack latency sweep across the timeout boundary. Ack driven d cycles after
    // accept is seen by the controller at accept+d+S+1; beyond T it times out.
    for (int it = 0; it < 8; it++) begin
      int            d;
      int            fall;
      logic          exp_err;
      logic [DW-1:0] w;
      d       = (it == 0) ? T - S - 1 : (it == 1) ? T - S : $urandom_range(0, T - S);
      fall    = (d + S + 1 < T) ? d + S + 1 : T;
      exp_err = (d + S + 1 > T);
      w       = DW'($urandom);
      accept_word(w);
      if (d == 0) ack_dir = 1'b1;
      for (int k = 1; k <= T; k++) begin
        tick();
        check("lat_req", xfer_req, k < fall);
        if (k == fall) begin
          check("lat_err", timeout_err, exp_err);
          check("lat_rel_busy", busy, 1'b1);
        end
        if (it == 1 && k == T - 1) err_clr = 1'b1;
        if (it == 1 && k == T) err_clr = 1'b0;
        if (k == d) ack_dir = 1'b1;
      end
      repeat (S + 1) tick();
      check("lat_rel_hold", busy, 1'b1);
      check("lat_data_held", xfer_data, w);
      ack_dir = 1'b0;
      for (int k = 1; k <= S + 1; k++) begin
        tick();
        check("lat_busy_release", busy, k < S + 1);
      end
      check("lat_ready_return", s_ready, 1'b1);
      check("lat_err_before_clr", timeout_err, exp_err);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("lat_err_cleared", timeout_err, 1'b0);
    end

    // Back-to-back stream with the far-side model answering
    auto_ack   = 1'b1;
    req_pulses = 0;
    rx_count   = 0;
    for (int i = 0; i < N_STREAM; i++) begin
      send_word_auto((i < 3) ? DW'(i + 1) : DW'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
    end
    s_valid = 1'b0;
    drain();
    check("stream_req_pulses", req_pulses, N_STREAM);
    check("stream_rx_count", rx_count, N_STREAM);
    check("stream_no_err", timeout_err, 1'b0);
    auto_ack = 1'b0;
    tick();

    // Ack stuck high across reset
    ack_dir = 1'b1;
    srst    = 1'b1;
    repeat (2) tick();
    check("stuck_rst_ready", s_ready, 1'b0);
    srst = 1'b0;
    repeat (S + 1) tick();
    repeat (3) begin
      tick();
      check("stuck_ready_low", s_ready, 1'b0);
      check("stuck_idle", busy, 1'b0);
    end
    ack_dir = 1'b0;
    for (int k = 1; k <= S; k++) begin
      tick();
      check("stuck_ready_return", s_ready, k == S);
    end

    // Reset in the middle of REQ, then a fresh transfer
    accept_word(8'h3C);
    repeat (2) tick();
    check("midrst_in_req", xfer_req, 1'b1);
    srst = 1'b1;
    #1;
    check("midrst_ready_low", s_ready, 1'b0);
    tick();
    check("midrst_req", xfer_req, 1'b0);
    check("midrst_data", xfer_data, '0);
    check("midrst_busy", busy, 1'b0);
    srst = 1'b0;
    tick();
    auto_ack = 1'b1;
    send_word_auto(8'h5A);
    s_valid = 1'b0;
    drain();
    check("midrst_fresh_data", xfer_data, 8'h5A);
    auto_ack = 1'b0;
    tick();

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cdc_hs_src
